// File: rtl/ram_access_arbiter.sv
// Single-port RAM arbiter for the RTC controller: grants the RAM port to the init FSM,
// the RTC register writer or the VGA read path, and returns registered VGA read data.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inic_req,
    input  logic [ADDR_W-1:0] inic_dir,
    input  logic [DATA_W-1:0] inic_data,
    input  logic              inic_we,
    input  logic              rtc_req,
    input  logic [ADDR_W-1:0] rtc_dir,
    input  logic [DATA_W-1:0] rtc_data,
    input  logic              rtc_we,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_dir,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              inic_gnt,
    output logic              rtc_gnt,
    output logic              vga_gnt,
    output logic [ADDR_W-1:0] ram_dir,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              busy
);

    localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        G_INIC = 2'd1,
        G_RTC  = 2'd2,
        G_VGA  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             rtc_preempted;
    logic             rd_pend;
    logic             hold_at_max;

    assign hold_at_max = (hold_cnt == HOLD_LAST);

    // Arbitration and tenure control; hold_cnt is zeroed in IDLE so every grant starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            rtc_preempted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (inic_req || rtc_req || vga_req) begin
                        rtc_preempted <= 1'b0;
                    end
                    if (inic_req) begin
                        state <= G_INIC;
                    end else if (rtc_preempted && vga_req) begin
                        state <= G_VGA;
                    end else if (rtc_req) begin
                        state <= G_RTC;
                    end else if (vga_req) begin
                        state <= G_VGA;
                    end
                end
                G_INIC: begin
                    if (!inic_req) begin
                        state <= IDLE;
                    end
                end
                G_RTC: begin
                    if (!rtc_req) begin
                        state <= IDLE;
                    end else if (hold_at_max && (inic_req || vga_req)) begin
                        state         <= IDLE;
                        rtc_preempted <= 1'b1;
                    end else if (!hold_at_max) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                G_VGA: begin
                    if (!vga_req) begin
                        state <= IDLE;
                    end else if (hold_at_max && (inic_req || rtc_req)) begin
                        state <= IDLE;
                    end else if (!hold_at_max) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inic_gnt = (state == G_INIC);
    assign rtc_gnt  = (state == G_RTC);
    assign vga_gnt  = (state == G_VGA);
    assign busy     = inic_gnt | rtc_gnt | vga_gnt;

    // Port mux: the owner's signals pass straight through during its grant.
    always_comb begin
        ram_dir = '0;
        ram_din = '0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state)
            G_INIC: begin
                ram_dir = inic_dir;
                ram_din = inic_data;
                ram_we  = inic_we;
            end
            G_RTC: begin
                ram_dir = rtc_dir;
                ram_din = rtc_data;
                ram_we  = rtc_we;
            end
            G_VGA: begin
                ram_dir = vga_dir;
                ram_re  = 1'b1;
            end
            default: ;
        endcase
    end

    // Read return: one cycle for the RAM, one for the capture register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend   <= 1'b0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            rd_pend   <= ram_re;
            vga_valid <= rd_pend;
            if (rd_pend) begin
                vga_data <= ram_dout;
            end
        end
    end

endmodule
